// File: rtl/text_term_writer.sv
// text_term_writer: character terminal engine feeding the VRAM write port.
// Interprets a byte stream (printables, CR, LF, BS, TAB, FF), tracks the
// cursor, scrolls by advancing top_row and clears rows/screen with blank cells.
// Optional feature macro: TERM_ATTR_ESC_EN (ESC <attr> sets the write attribute).
module text_term_writer #(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 30,
  parameter int         ADDR_W   = 13,
  parameter logic [7:0] DEF_ATTR = 8'h0F,
  parameter int         TAB_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [15:0]       vram_wdata,
  input  logic              vram_wready,
  output logic [4:0]        top_row,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = 5;

  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_LCOL = ADDR_W'(COLS - 1);
  localparam logic [COL_W-1:0]  MAX_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  MAX_ROW   = ROW_W'(ROWS - 1);
  localparam logic [15:0]       CLR_WORD  = {DEF_ATTR, 8'h20};

`ifdef TERM_ATTR_ESC_EN
  typedef enum logic [2:0] {IDLE, PUT, CLRLINE, CLS, ESC} state_t;
`else
  typedef enum logic [2:0] {IDLE, PUT, CLRLINE, CLS} state_t;
`endif

  state_t state, state_n;

  logic [COL_W-1:0]  col, col_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [ROW_W-1:0]  top_r, top_n;
  logic [ADDR_W-1:0] prow_base, base_n;   // physical row index * COLS of cursor row
  logic [ADDR_W-1:0] clr_cnt, cnt_n;
  logic              pend_clr, pend_n;    // PUT wrapped off the bottom row
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       wdata_n;
  logic              rdy_n, busy_n;
  logic [7:0]        attr;

  logic              accept;
  logic              scroll;
  logic [ROW_W-1:0]  row_nl, top_nl;
  logic [ADDR_W-1:0] base_nl, cur_addr;

`ifdef TERM_ATTR_ESC_EN
  logic [7:0] attr_n;
`else
  assign attr = DEF_ATTR;
`endif

  // Next tab stop after column c, saturated at the last column.
  function automatic logic [COL_W-1:0] tab_stop(input logic [COL_W-1:0] c);
    logic [COL_W:0] nxt;
    nxt = ({1'b0, c} | (COL_W + 1)'(TAB_W - 1)) + (COL_W + 1)'(1);
    if (nxt > {1'b0, MAX_COL}) return MAX_COL;
    return nxt[COL_W-1:0];
  endfunction

  assign accept   = in_valid && in_ready;
  assign scroll   = (row == MAX_ROW);
  assign row_nl   = scroll ? row : row + ROW_W'(1);
  assign top_nl   = scroll ? ((top_r == MAX_ROW) ? '0 : top_r + ROW_W'(1)) : top_r;
  assign base_nl  = (prow_base == LAST_BASE) ? '0 : prow_base + COLS_A;
  assign cur_addr = prow_base + ADDR_W'(col);
  assign top_row  = top_r;

  // Next-state, cursor and VRAM write request decode.
  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    top_n   = top_r;
    base_n  = prow_base;
    cnt_n   = clr_cnt;
    pend_n  = pend_clr;
    we_n    = vram_we;
    addr_n  = vram_addr;
    wdata_n = vram_wdata;
`ifdef TERM_ATTR_ESC_EN
    attr_n  = attr;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            state_n = PUT;
            we_n    = 1'b1;
            addr_n  = cur_addr;
            wdata_n = {attr, in_data};
            if (col == MAX_COL) begin
              col_n  = '0;
              row_n  = row_nl;
              top_n  = top_nl;
              base_n = base_nl;
              pend_n = scroll;
            end else begin
              col_n = col + COL_W'(1);
            end
          end else begin
            unique case (in_data)
              8'h0D: col_n = '0;
              8'h0A: begin
                row_n  = row_nl;
                top_n  = top_nl;
                base_n = base_nl;
                if (scroll) begin
                  state_n = CLRLINE;
                  we_n    = 1'b1;
                  addr_n  = base_nl;
                  wdata_n = CLR_WORD;
                  cnt_n   = '0;
                end
              end
              8'h08: if (col != '0) col_n = col - COL_W'(1);
              8'h09: col_n = tab_stop(col);
              8'h0C: begin
                state_n = CLS;
                we_n    = 1'b1;
                addr_n  = '0;
                wdata_n = CLR_WORD;
                cnt_n   = '0;
              end
`ifdef TERM_ATTR_ESC_EN
              8'h1B: state_n = ESC;
`endif
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        if (vram_we && vram_wready) begin
          if (pend_clr) begin
            state_n = CLRLINE;
            pend_n  = 1'b0;
            addr_n  = prow_base;
            wdata_n = CLR_WORD;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
            we_n    = 1'b0;
          end
        end
      end
      CLRLINE: begin
        if (!vram_we) begin
          we_n = 1'b1;
        end else if (vram_wready) begin
          if (addr_n == vram_addr && clr_cnt == LAST_LCOL) begin
            state_n = IDLE;
            we_n    = 1'b0;
          end else begin
            addr_n = vram_addr + ADDR_W'(1);
            cnt_n  = clr_cnt + ADDR_W'(1);
          end
        end
      end
      CLS: begin
        if (!vram_we) begin
          we_n    = 1'b1;
          addr_n  = '0;
          wdata_n = CLR_WORD;
          cnt_n   = '0;
        end else if (vram_wready) begin
          if (clr_cnt == LAST_CELL) begin
            state_n = IDLE;
            we_n    = 1'b0;
            col_n   = '0;
            row_n   = '0;
            top_n   = '0;
            base_n  = '0;
          end else begin
            addr_n = vram_addr + ADDR_W'(1);
            cnt_n  = clr_cnt + ADDR_W'(1);
          end
        end
      end
`ifdef TERM_ATTR_ESC_EN
      ESC: begin
        if (accept) begin
          attr_n  = in_data;
          state_n = IDLE;
        end
      end
`endif
      default: state_n = CLS;
    endcase

`ifdef TERM_ATTR_ESC_EN
    rdy_n  = (state_n == IDLE) || (state_n == ESC);
`else
    rdy_n  = (state_n == IDLE);
`endif
    busy_n = (state_n == CLS) || (state_n == CLRLINE);
  end

  // State register; reset parks the engine in CLS so the screen is wiped.
  always_ff @(posedge clk) begin
    if (rst) state <= CLS;
    else     state <= state_n;
  end

  // Cursor, scroll and VRAM port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      top_r       <= '0;
      prow_base   <= '0;
      clr_cnt     <= '0;
      pend_clr    <= 1'b0;
      vram_we     <= 1'b0;
      vram_addr   <= '0;
      vram_wdata  <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b1;
      cursor_addr <= '0;
`ifdef TERM_ATTR_ESC_EN
      attr        <= DEF_ATTR;
`endif
    end else begin
      col         <= col_n;
      row         <= row_n;
      top_r       <= top_n;
      prow_base   <= base_n;
      clr_cnt     <= cnt_n;
      pend_clr    <= pend_n;
      vram_we     <= we_n;
      vram_addr   <= addr_n;
      vram_wdata  <= wdata_n;
      in_ready    <= rdy_n;
      busy        <= busy_n;
      cursor_addr <= cur_addr;
`ifdef TERM_ATTR_ESC_EN
      attr        <= attr_n;
`endif
    end
  end

endmodule

// File: tb/tb_text_term_writer.sv
// Directed testbench for text_term_writer (default 80x30 geometry).
module tb_text_term_writer;

  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [15:0]       vram_wdata;
  logic              vram_wready = 1'b1;
  logic [4:0]        top_row;
  logic [ADDR_W-1:0] cursor_addr;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] qa[$];
  logic [15:0]       qd[$];

  text_term_writer dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_wdata  (vram_wdata),
    .vram_wready (vram_wready),
    .top_row     (top_row),
    .cursor_addr (cursor_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Log every accepted VRAM write.
  always @(posedge clk) begin
    if (!rst && vram_we && vram_wready) begin
      qa.push_back(vram_addr);
      qd.push_back(vram_wdata);
    end
  end

  task automatic clear_log();
    qa.delete();
    qd.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL send_ready_timeout byte=%h in_ready=%b required=1", b, in_ready);
    end
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && !busy && !vram_we) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL idle_timeout busy=%b in_ready=%b required idle", busy, in_ready);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    vram_wready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rst_vram_we got=%b exp=0", vram_we); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", busy); end
    checks++; if (top_row !== 5'd0) begin errors++; $display("FAIL rst_top_row got=%0d exp=0", top_row); end
    checks++; if (cursor_addr !== '0) begin errors++; $display("FAIL rst_cursor got=%0d exp=0", cursor_addr); end
    checks++; if (vram_addr !== '0 || vram_wdata !== 16'h0) begin
      errors++; $display("FAIL rst_vram_port got=%0d/%h exp=0/0000", vram_addr, vram_wdata);
    end
    clear_log();
    rst = 1'b0;
    wait_idle();
    bad = 0;
    for (int i = 0; i < qa.size(); i++)
      if (qa[i] !== ADDR_W'(i) || qd[i] !== 16'h0F20) bad++;
    checks++;
    if (qa.size() != 2400 || bad != 0) begin
      errors++; $display("FAIL cls_sweep writes=%0d bad=%0d exp=2400/0", qa.size(), bad);
    end
    checks++; if (top_row !== 5'd0 || cursor_addr !== '0) begin
      errors++; $display("FAIL cls_home top=%0d cur=%0d exp=0/0", top_row, cursor_addr);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cls_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_put_crlf();
    clear_log();
    send(8'h41); send(8'h42); send(8'h0D); send(8'h0A); send(8'h43);
    wait_idle();
    checks++;
    if (qa.size() != 3) begin
      errors++; $display("FAIL put_count got=%0d exp=3", qa.size());
    end else begin
      if (qa[0] !== 13'd0 || qd[0] !== 16'h0F41) begin errors++; $display("FAIL put_A got=%0d/%h exp=0/0f41", qa[0], qd[0]); end
      checks++;
      if (qa[1] !== 13'd1 || qd[1] !== 16'h0F42) begin errors++; $display("FAIL put_B got=%0d/%h exp=1/0f42", qa[1], qd[1]); end
      checks++;
      if (qa[2] !== 13'd80 || qd[2] !== 16'h0F43) begin errors++; $display("FAIL put_C got=%0d/%h exp=80/0f43", qa[2], qd[2]); end
    end
    checks++; if (cursor_addr !== 13'd81) begin errors++; $display("FAIL put_cursor got=%0d exp=81", cursor_addr); end
  endtask

  task automatic test_scroll();
    int bad;
    send(8'h0C);
    wait_idle();
    repeat (29) send(8'h0A);
    wait_idle();
    checks++; if (top_row !== 5'd0 || cursor_addr !== 13'd2320) begin
      errors++; $display("FAIL lf29 top=%0d cur=%0d exp=0/2320", top_row, cursor_addr);
    end
    clear_log();
    send(8'h0A);
    wait_idle();
    bad = 0;
    for (int i = 0; i < qa.size(); i++)
      if (qa[i] !== ADDR_W'(i) || qd[i] !== 16'h0F20) bad++;
    checks++; if (qa.size() != 80 || bad != 0) begin
      errors++; $display("FAIL scroll_clear writes=%0d bad=%0d exp=80/0", qa.size(), bad);
    end
    checks++; if (top_row !== 5'd1 || cursor_addr !== 13'd0) begin
      errors++; $display("FAIL scroll_pos top=%0d cur=%0d exp=1/0", top_row, cursor_addr);
    end
  endtask

  task automatic test_stall();
    int bad;
    clear_log();
    vram_wready = 1'b0;
    send(8'h5A);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (vram_we !== 1'b1 || vram_addr !== 13'd0 || vram_wdata !== 16'h0F5A || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL stall_hold bad_cycles=%0d exp=0 we=%b addr=%0d data=%h", bad, vram_we, vram_addr, vram_wdata);
    end
    vram_wready = 1'b1;
    wait_idle();
    checks++; if (qa.size() != 1 || qd[0] !== 16'h0F5A || qa[0] !== 13'd0) begin
      errors++; $display("FAIL stall_write writes=%0d exp=1 (0f5a@0)", qa.size());
    end
  endtask

  task automatic test_wrap_bs_tab();
    send(8'h0C);
    wait_idle();
    repeat (10) send(8'h09);
    wait_idle();
    checks++; if (cursor_addr !== 13'd79) begin errors++; $display("FAIL tab_sat got=%0d exp=79", cursor_addr); end
    clear_log();
    send(8'h58);
    wait_idle();
    checks++; if (qa.size() != 1 || qa[0] !== 13'd79 || qd[0] !== 16'h0F58) begin
      errors++; $display("FAIL wrap_X writes=%0d exp=1 (0f58@79)", qa.size());
    end
    checks++; if (cursor_addr !== 13'd80) begin errors++; $display("FAIL wrap_cursor got=%0d exp=80", cursor_addr); end
    send(8'h08);
    wait_idle();
    checks++; if (cursor_addr !== 13'd80) begin errors++; $display("FAIL bs_col0 got=%0d exp=80", cursor_addr); end
    send(8'h61); send(8'h62); send(8'h63); send(8'h09);
    wait_idle();
    checks++; if (cursor_addr !== 13'd88) begin errors++; $display("FAIL tab_3 got=%0d exp=88", cursor_addr); end
  endtask

  task automatic test_wrap_bottom();
    int bad;
    send(8'h0C);
    wait_idle();
    repeat (29) send(8'h0A);
    repeat (10) send(8'h09);
    wait_idle();
    checks++; if (cursor_addr !== 13'd2399) begin errors++; $display("FAIL corner_cursor got=%0d exp=2399", cursor_addr); end
    clear_log();
    send(8'h57);
    wait_idle();
    bad = 0;
    for (int i = 1; i < qa.size(); i++)
      if (qa[i] !== ADDR_W'(i - 1) || qd[i] !== 16'h0F20) bad++;
    checks++; if (qa.size() != 81 || bad != 0 || qa[0] !== 13'd2399 || qd[0] !== 16'h0F57) begin
      errors++; $display("FAIL corner_seq writes=%0d bad=%0d exp=81/0", qa.size(), bad);
    end
    checks++; if (top_row !== 5'd1 || cursor_addr !== 13'd0) begin
      errors++; $display("FAIL corner_pos top=%0d cur=%0d exp=1/0", top_row, cursor_addr);
    end
  endtask

  task automatic test_esc();
    logic [15:0] exp_w;
`ifdef TERM_ATTR_ESC_EN
    exp_w = 16'h1E51;
`else
    exp_w = 16'h0F51;
`endif
    send(8'h0C);
    wait_idle();
    clear_log();
    send(8'h1B); send(8'h1E); send(8'h51);
    wait_idle();
    checks++; if (qa.size() != 1 || qa[0] !== 13'd0 || qd[0] !== exp_w) begin
      errors++; $display("FAIL esc_write writes=%0d exp=1 (%h@0)", qa.size(), exp_w);
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    send(8'h0C);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (vram_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || vram_addr !== '0) begin
      errors++; $display("FAIL abort_outputs we=%b rdy=%b busy=%b addr=%0d exp=0/0/1/0", vram_we, in_ready, busy, vram_addr);
    end
    clear_log();
    @(negedge clk);
    rst = 1'b0;
    wait_idle();
    bad = 0;
    for (int i = 0; i < qa.size(); i++)
      if (qa[i] !== ADDR_W'(i) || qd[i] !== 16'h0F20) bad++;
    checks++; if (qa.size() != 2400 || bad != 0) begin
      errors++; $display("FAIL abort_cls writes=%0d bad=%0d exp=2400/0", qa.size(), bad);
    end
  endtask

  initial begin
    test_reset();
    test_put_crlf();
    test_scroll();
    test_stall();
    test_wrap_bs_tab();
    test_wrap_bottom();
    test_esc();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_term_writer.md
Name: text_term_writer

Overview:
- Host-side character terminal engine that sits directly upstream of the video RAM stage.
- Accepts a byte stream over a valid/ready handshake and interprets control codes.
- Tracks the cursor and issues 16-bit character/attribute writes into the VRAM write port.
- Handles hardware scrolling through a top-row offset consumed by the VDU. Also supplies the cursor word address used for cursor highlighting.

Parameters:
- COLS, 80, text columns per row
- ROWS, 30, text rows on screen
- ADDR_W, 13, VRAM word address width
- DEF_ATTR, 8'h0F, attribute byte used after reset and for all cleared cells
- TAB_W, 8, tab stop spacing (power of two)

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  incoming character byte
- in_valid  in  1  in_data valid
- in_ready  out  1  engine can accept a byte this cycle
- vram_we  out  1  write request to VRAM
- vram_addr  out  ADDR_W  VRAM word address
- vram_wdata  out  16  {attr[7:0], char[7:0]}
- vram_wready  in  1  VRAM accepts the presented write this cycle
- top_row  out  5  physical row displayed at screen top (scroll offset)
- cursor_addr  out  ADDR_W  physical word address under the cursor
- busy  out  1  clear or scroll in progress

Behaviour:
- Single clock. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - in_ready=0, vram_we=0, vram_addr=0, vram_wdata=0, top_row=0, cursor_addr=0, busy=1.
  - Cursor col=0, row=0; attr=DEF_ATTR.
  - State forced to CLS on the cycle after rst deasserts.
- States:
  - IDLE: in_ready=1, busy=0.
  - PUT: single write.
  - CLRLINE: clears one physical row, COLS writes.
  - CLS: clears all ROWS*COLS words, then cursor home and top_row=0.
  - ESC: optional, see below.
- A byte is accepted when in_valid && in_ready. in_ready is high only in IDLE, and is registered (never combinational from in_valid).
- Decode of an accepted byte:
  - 0x20..0x7E: enter PUT. Write {attr, byte} at cursor, then col+1. If col was COLS-1: col=0 and perform newline.
  - 0x0D CR: col=0; stay IDLE.
  - 0x0A LF: perform newline.
  - 0x08 BS: col=col-1 if col>0; no erase; stay IDLE.
  - 0x09 TAB: col = next multiple of TAB_W, saturated at COLS-1.
  - 0x0C FF: enter CLS.
  - All other bytes ignored, consumed with no effect.
- Newline:
  - If row<ROWS-1, row+1.
  - Else row stays ROWS-1, top_row=(top_row+1) mod ROWS, and the new bottom physical row is cleared via CLRLINE.
- Physical row = (top_row+row) mod ROWS. Word address = prow*COLS+col; compute with a running row-base register, no multiplier.
- cursor_addr is updated the cycle after any cursor or top_row change.
- VRAM write handshake: vram_we/addr/wdata are held stable until a cycle with vram_we && vram_wready. The next write or state transition occurs on the following edge. vram_we never drops before acceptance.
- Clear writes use {DEF_ATTR, 8'h20}, with addresses ascending within the row or screen.
- Timing with vram_wready tied high:
  - PUT: 1 write, back to IDLE after 1 cycle.
  - CLRLINE: COLS cycles.
  - CLS: ROWS*COLS cycles.
- rst asserted mid-operation aborts any write or clear immediately. The pending write is dropped, outputs return to reset values, and CLS restarts.
- A write at col COLS-1, row ROWS-1 completes PUT first, then CLRLINE, then returns to IDLE.

Optional Feature:
- Macro: TERM_ATTR_ESC_EN.
- When defined:
  - Byte 0x1B enters ESC with in_ready=1.
  - The next accepted byte is loaded into attr with no write, then back to IDLE.
  - FF and CLRLINE still use DEF_ATTR; attr persists across clears and is reset to DEF_ATTR by rst.
- When undefined:
  - 0x1B is ignored like any other control byte.
  - attr is constant DEF_ATTR; no ESC state exists.

Test Plan:
- Reset then wvready=1: exactly 2400 writes of 16'h0F20 to addrs 0..2399 in order; in_ready rises after the last one; top_row=0, cursor_addr=0.
- Send "AB\r\n" then 'C': writes 16'h0F41@0 and 16'h0F42@1, then 16'h0F43@80; cursor_addr=81.
- Fill 30 rows with LFs from row 0, i.e. 30 LFs: the last LF sets top_row=1 and clears addrs 0..79 with 0F20; cursor_addr=0 (physical row 0 now at bottom).
- Hold vram_wready=0 for 5 cycles during PUT of 'Z': vram_we/addr/wdata stable for all 5 cycles; exactly one write of 16'h0F5A; in_ready low until it completes.
- Cursor at col 79 with 'X', then BS, TAB at col 3: 'X' written at col 79, cursor wraps to col 0 of the next row; BS at col 0 leaves col 0; TAB from col 3 gives col 8.
- With TERM_ATTR_ESC_EN, send 0x1B,0x1E,'Q': writes 16'h1E51. Without the macro, the same stream writes 16'h0F1E? no — 0x1E is ignored, so only 16'h0F51 is written.
